// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, frame format and receiver state type
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    // Line levels of the framing bits, common to transmitter and receiver
    localparam logic FRAME_START_BIT = 1'b0;
    localparam logic FRAME_STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for the serial line with falling-edge detect
module uart_rx_sync (
    input  logic rxclk,
    input  logic reset_n,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Reset to the idle-high level so a line already low at release reads as one falling edge
    always_ff @(posedge rxclk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rx_s = r_sync;
    assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with one-entry holding register
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 rxclk,
    input  logic                 reset_n,
    input  logic                 uld_rx_data,
    output logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_enable,
    input  logic                 rx_in,
    output logic                 rx_empty,
    output logic                 rx_frame_err,
    output logic                 rx_over_run
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic                 w_rx_s;
    logic                 w_fall;
    logic                 w_complete;

    uart_state_t          r_state;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_empty;
    logic                 r_frame_err;
    logic                 r_over_run;

    uart_rx_sync u_sync (
        .rxclk   (rxclk),
        .reset_n (reset_n),
        .i_rx    (rx_in),
        .o_rx_s  (w_rx_s),
        .o_fall  (w_fall)
    );

    assign w_complete = rx_enable && (r_state == ST_STOP) && (r_cnt == CNT_LAST);

    always_ff @(posedge rxclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else if (!rx_enable) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state <= ST_START;
                        r_cnt   <= '0;
                    end
                end
                ST_START: begin
                    // Mid-start-bit recheck rejects short glitches on the line
                    if (r_cnt == CNT_HALF) begin
                        r_cnt <= '0;
                        if (w_rx_s != FRAME_START_BIT) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state   <= ST_DATA;
                            r_bit_idx <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_shift[r_bit_idx] <= w_rx_s;
                        r_cnt              <= '0;
                        if (r_bit_idx == LAST_BIT) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + BW'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // A completing frame takes priority over a simultaneous unload
    always_ff @(posedge rxclk or negedge reset_n) begin
        if (!reset_n) begin
            r_data      <= '0;
            r_empty     <= 1'b1;
            r_frame_err <= 1'b0;
            r_over_run  <= 1'b0;
        end else if (w_complete) begin
            r_data      <= r_shift;
            r_frame_err <= (w_rx_s != FRAME_STOP_BIT);
            r_empty     <= 1'b0;
            if (!r_empty && !uld_rx_data) begin
                r_over_run <= 1'b1;
            end else if (uld_rx_data) begin
                r_over_run <= 1'b0;
            end
        end else if (uld_rx_data) begin
            r_empty    <= 1'b1;
            r_over_run <= 1'b0;
        end
    end

    assign rx_data      = r_data;
    assign rx_empty     = r_empty;
    assign rx_frame_err = r_frame_err;
    assign rx_over_run  = r_over_run;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

    localparam int OS  = 16;
    localparam int DB  = 8;
    localparam int LAT = 155;

    logic       rxclk       = 1'b0;
    logic       reset_n     = 1'b0;
    logic       uld_rx_data = 1'b0;
    logic       rx_enable   = 1'b0;
    logic       rx_in       = 1'b1;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       rx_frame_err;
    logic       rx_over_run;

    int n_checks = 0;
    int n_errors = 0;
    int lat;

    always #5 rxclk = ~rxclk;

    uart_rx #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB)
    ) dut (
        .rxclk        (rxclk),
        .reset_n      (reset_n),
        .uld_rx_data  (uld_rx_data),
        .rx_data      (rx_data),
        .rx_enable    (rx_enable),
        .rx_in        (rx_in),
        .rx_empty     (rx_empty),
        .rx_frame_err (rx_frame_err),
        .rx_over_run  (rx_over_run)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_rx(input string tag, input logic [7:0] d, input logic empty,
                            input logic fe, input logic ovr);
        check({tag, "_data"}, rx_data, d);
        check({tag, "_empty"}, rx_empty, empty);
        check({tag, "_frame_err"}, rx_frame_err, fe);
        check({tag, "_over_run"}, rx_over_run, ovr);
    endtask

    // Called at a falling clock edge; returns at a falling edge
    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx_in = 1'b0;
        repeat (OS) @(negedge rxclk);
        for (int i = 0; i < DB; i++) begin
            rx_in = d[i];
            repeat (OS) @(negedge rxclk);
        end
        rx_in = stop;
        repeat (OS) @(negedge rxclk);
        rx_in = 1'b1;
        repeat (4) @(negedge rxclk);
    endtask

    task automatic unload();
        uld_rx_data = 1'b1;
        @(negedge rxclk);
        uld_rx_data = 1'b0;
        @(negedge rxclk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge rxclk);
        check_rx("reset", 8'h00, 1'b1, 1'b0, 1'b0);
        reset_n   = 1'b1;
        rx_enable = 1'b1;
        repeat (4) @(negedge rxclk);

        // Basic frame and latency
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                while (rx_empty === 1'b1 && lat < 400) begin
                    @(negedge rxclk);
                    lat++;
                end
            end
        join
        check("a5_latency_in_window", 32'(lat >= LAT - 1 && lat <= LAT + 1), 1);
        check_rx("a5", 8'hA5, 1'b0, 1'b0, 1'b0);
        unload();
        check("a5_unload_empty", rx_empty, 1'b1);

        // Short low glitch must not start a frame
        rx_in = 1'b0;
        repeat (4) @(negedge rxclk);
        rx_in = 1'b1;
        repeat (40) @(negedge rxclk);
        check("glitch_empty", rx_empty, 1'b1);
        send_frame(8'h3C, 1'b1);
        check_rx("3c", 8'h3C, 1'b0, 1'b0, 1'b0);
        unload();

        // Framing error, then cleared by a good frame
        send_frame(8'h55, 1'b0);
        check_rx("55_bad_stop", 8'h55, 1'b0, 1'b1, 1'b0);
        unload();
        send_frame(8'h0F, 1'b1);
        check_rx("0f", 8'h0F, 1'b0, 1'b0, 1'b0);
        unload();

        // Overrun and its clear
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check_rx("ovr", 8'h22, 1'b0, 1'b0, 1'b1);
        unload();
        check("ovr_uld_over_run", rx_over_run, 1'b0);
        check("ovr_uld_empty", rx_empty, 1'b1);

        // Unload coinciding with completion of the second frame
        send_frame(8'h11, 1'b1);
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (LAT - 1) @(negedge rxclk);
                uld_rx_data = 1'b1;
                @(negedge rxclk);
                uld_rx_data = 1'b0;
            end
        join
        check_rx("uld_on_complete", 8'h22, 1'b0, 1'b0, 1'b0);
        unload();

        // Enable dropped after bit 3 discards the frame in progress
        fork
            send_frame(8'hC3, 1'b1);
            begin
                repeat (OS * 5 + 8) @(negedge rxclk);
                rx_enable = 1'b0;
                repeat (10) @(negedge rxclk);
                rx_enable = 1'b1;
            end
        join
        check("disable_empty", rx_empty, 1'b1);
        check("disable_frame_err", rx_frame_err, 1'b0);
        check("disable_over_run", rx_over_run, 1'b0);
        send_frame(8'h81, 1'b1);
        check_rx("81", 8'h81, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-frame, then a break on the line
        rx_in = 1'b0;
        repeat (50) @(negedge rxclk);
        #2 reset_n = 1'b0;
        #1 check_rx("async_reset", 8'h00, 1'b1, 1'b0, 1'b0);
        @(negedge rxclk);
        repeat (2) @(negedge rxclk);
        reset_n = 1'b1;
        lat = 0;
        while (rx_empty === 1'b1 && lat < 300) begin
            @(negedge rxclk);
            lat++;
        end
        check_rx("break", 8'h00, 1'b0, 1'b1, 1'b0);
        unload();
        repeat (160) @(negedge rxclk);
        check("break_no_refire_empty", rx_empty, 1'b1);
        check("break_frame_err_holds", rx_frame_err, 1'b1);
        rx_in = 1'b1;
        repeat (8) @(negedge rxclk);
        send_frame(8'h5A, 1'b1);
        check_rx("after_break", 8'h5A, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the receive-side counterpart to the team's uart_tx. It takes the serial line into rxclk, which runs at OVERSAMPLE× the baud rate, and synchronises it. It detects and validates the start bit, samples DATA_BITS data bits LSB-first at mid-bit, and checks the stop bit. The received byte is presented through a one-entry holding register with an empty flag and unload strobe. Framing and overrun errors are flagged.

Parameters:
OVERSAMPLE, 16, rxclk cycles per bit; even, ≥4
DATA_BITS, 8, data bits per frame; 5..8

Ports:
rxclk  input  1  receive clock, OVERSAMPLE × baud
reset_n  input  1  reset
uld_rx_data  input  1  unload strobe; consumer has taken rx_data
rx_data  output  DATA_BITS  last received byte
rx_enable  input  1  receiver enable
rx_in  input  1  serial line, idle high, asynchronous
rx_empty  output  1  1 = holding register holds no unread byte
rx_frame_err  output  1  last frame had stop bit = 0
rx_over_run  output  1  a byte arrived while the previous was unread

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset values (reset_n low): rx_data=0, rx_empty=1, rx_frame_err=0, rx_over_run=0, FSM=IDLE, counters=0, synchroniser flops=1.
- rx_in passes through 2 flops (rx_s); the edge detector compares rx_s with its previous value.
- FSM states: IDLE, START, DATA, STOP; 4-bit-wide-enough sample counter cnt; bit index bit_idx.
- IDLE: on a falling edge of rx_s (prev=1, cur=0) → START, cnt=0. A line held low (break) never retriggers; a high level is required first.
- START: cnt increments. At cnt==OVERSAMPLE/2-1:
  - rx_s=1 → false start, back to IDLE, no flag change.
  - else → DATA, cnt=0, bit_idx=0.
- DATA: at cnt==OVERSAMPLE-1, shift rx_s into bit position bit_idx (LSB first), cnt=0, bit_idx++. After bit DATA_BITS-1 → STOP.
- STOP: at cnt==OVERSAMPLE-1, sample the stop bit, complete the frame, → IDLE.
- Frame completion, a single cycle:
  - rx_data ← shifted byte, even on framing error.
  - rx_frame_err ← ~stop_sample.
  - rx_empty ← 0.
  - If rx_empty was 0 and uld_rx_data is not asserted that cycle: rx_over_run ← 1, and the new byte overwrites the old.
- uld_rx_data: rx_empty ← 1 and rx_over_run ← 0 next edge.
  - Coinciding with frame completion: completion wins, rx_empty=0 and no overrun.
- rx_frame_err is updated only at frame completion; otherwise it holds.
- rx_enable=0: FSM → IDLE, cnt and bit_idx cleared on the next edge. rx_data, rx_empty and the error flags hold, and uld_rx_data still works. A frame in progress is discarded.
- Latency: from the rx_in falling edge to rx_empty=0 is 2 (sync) + 1 (edge) + OVERSAMPLE/2 + (DATA_BITS+1)·OVERSAMPLE cycles, ±1. With defaults this is 155 ±1 cycles.
- Tolerates ±3% baud mismatch by mid-bit sampling. No majority voting.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is lost.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE, START, DATA, STOP)
  - default OVERSAMPLE and DATA_BITS constants
  - frame-format constants (start=0, stop=1), shared with uart_tx
- One sub-module, uart_rx_sync: 2-flop synchroniser plus registered previous value, outputs rx_s and fall. Reset value 1.

Test Plan:
- Enable=1, send 0xA5 (8N1, 16 cycles/bit, LSB first) → rx_empty falls at 155±1 cycles; rx_data=0xA5, frame_err=0, over_run=0. Pulse uld → rx_empty=1.
- Glitch: rx_in low for 4 cycles, then high → no state change; rx_empty stays 1. A following valid 0x3C is received correctly.
- Send 0x55 with stop bit=0 → rx_data=0x55, rx_empty=0, frame_err=1. Next good frame 0x0F → frame_err=0.
- Send 0x11, no unload, send 0x22 → rx_data=0x22, over_run=1. uld → over_run=0, rx_empty=1. Repeat with uld asserted exactly on the completion cycle of 0x22 → rx_empty=0, over_run=0.
- Drop rx_enable mid-byte (after bit 3), restore, send 0x81 → only 0x81 is delivered; no partial byte, no error flags.
- Assert reset_n=0 asynchronously mid-frame → outputs immediately take reset values. Then a break (rx_in held 0 for 20 bit times) → exactly one frame with rx_data=0x00 and frame_err=1, and no further frames until rx_in returns high.
